sram_like_bridge: RTL and testbench

- Converts the core's SRAM-like request channel (req/addr_ok/data_ok) to a synchronous SRAM port of configurable read latency.
- Sits between the mips core and each instruction or data SRAM, one instance per port.
- Supersedes the fixed combinational glue in the top level:
  - parametrised address/data width, SRAM latency and response buffering;
  - credit-based flow control;
  - master back-pressure on responses;
  - correct byte-enable generation.

---
 rtl/sram_like_bridge.sv | 163 ++++++++++++++++
 tb/tb_sram_like_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_bridge.sv
// Bridges the core's SRAM-like req/addr_ok/data_ok channel to a synchronous SRAM of latency SRAM_LAT.
// Optional request/stall counters are compiled in when SRAM_LIKE_BRIDGE_STATS_EN is defined.
module sram_like_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SRAM_LAT   = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic [DATA_W-1:0] rdata,
  output logic              data_ok,
  input  logic              data_ready,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
`ifdef SRAM_LIKE_BRIDGE_STATS_EN
  ,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_stall
`endif
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(RESP_DEPTH - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SRAM_LAT-1:0] vld_q, vld_d;
  logic [SRAM_LAT-1:0] tag_wr_q, tag_wr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic [DATA_W-1:0]   resp_mem [RESP_DEPTH];

  logic       accept, arrival, arr_wr;
  logic       fifo_empty, fifo_full;
  logic       pop, deq, push;
  logic [3:0] byte_en;

  // Reserved size 3 falls into the word case on purpose.
  always_comb begin
    case (size)
      2'd0:    byte_en = 4'b0001 << addr[1:0];
      2'd1:    byte_en = 4'b0011 << addr[1:0];
      default: byte_en = 4'b1111;
    endcase
  end

  // Gating with resetn keeps addr_ok/sram_en low for the whole reset, not just after the first edge.
  always_comb begin
    accept     = resetn && req && (cnt_q < DEPTH_C);
    addr_ok    = accept;
    arrival    = vld_q[SRAM_LAT-1];
    arr_wr     = tag_wr_q[SRAM_LAT-1];
    fifo_empty = (fill_q == '0);
    fifo_full  = (fill_q == DEPTH_C);
    data_ok    = !fifo_empty || arrival;
    rdata      = fifo_empty ? sram_rdata : resp_mem[rd_ptr_q];
    pop        = data_ok && data_ready;
    deq        = pop && !fifo_empty;
    push       = arrival && !(fifo_empty && pop);

    sram_en    = accept;
    sram_wen   = (accept && wr) ? byte_en : 4'b0000;
    sram_addr  = {addr[ADDR_W-1:2], 2'b00};
    sram_wdata = wdata;
  end

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;

    vld_d       = '0;
    tag_wr_d    = '0;
    vld_d[0]    = accept;
    tag_wr_d[0] = wr;
    for (int i = 1; i < SRAM_LAT; i++) begin
      vld_d[i]    = vld_q[i-1];
      tag_wr_d[i] = tag_wr_q[i-1];
    end

    rd_ptr_d = rd_ptr_q;
    if (deq) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;

    fill_d = fill_q;
    if (push && !deq)      fill_d = fill_q + 1'b1;
    else if (!push && deq) fill_d = fill_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      vld_q    <= '0;
      tag_wr_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      tag_wr_q <= tag_wr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: the response storage is not reset; the pointers and fill count alone say which entries are live.
  always_ff @(posedge clk) begin
    if (push) resp_mem[wr_ptr_q] <= arr_wr ? '0 : sram_rdata;
  end

  // Credit accounting guarantees room for every arrival.
  assert property (@(posedge clk) disable iff (!resetn) !(push && fifo_full));

`ifdef SRAM_LIKE_BRIDGE_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_rd_d    = stat_rd_q;
    stat_wr_d    = stat_wr_q;
    stat_stall_d = stat_stall_q;
    if (accept && !wr)    stat_rd_d    = stat_rd_q + 1'b1;
    if (accept && wr)     stat_wr_d    = stat_wr_q + 1'b1;
    if (req && !addr_ok)  stat_stall_d = stat_stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_rd_q    <= stat_rd_d;
      stat_wr_q    <= stat_wr_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_rd    = stat_rd_q;
  assign stat_wr    = stat_wr_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: one instance at SRAM_LAT=1 and one at SRAM_LAT=2,
// sharing the master-side stimulus, each with its own behavioural SRAM.
module tb_sram_like_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, req, wr, data_ready;
  logic [1:0]  size;
  logic [31:0] addr, wdata;

  logic        a_addr_ok, a_data_ok, a_en;
  logic [3:0]  a_wen;
  logic [31:0] a_rdata, a_saddr, a_swdata, a_srdata;
  logic        b_addr_ok, b_data_ok, b_en;
  logic [3:0]  b_wen;
  logic [31:0] b_rdata, b_saddr, b_swdata, b_srdata;
`ifdef SRAM_LIKE_BRIDGE_STATS_EN
  logic [31:0] a_st_rd, a_st_wr, a_st_stall, b_st_rd, b_st_wr, b_st_stall;
`endif

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(1), .RESP_DEPTH(4)) u_lat1 (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(a_addr_ok), .rdata(a_rdata), .data_ok(a_data_ok), .data_ready(data_ready),
    .sram_en(a_en), .sram_wen(a_wen), .sram_addr(a_saddr), .sram_wdata(a_swdata),
    .sram_rdata(a_srdata)
`ifdef SRAM_LIKE_BRIDGE_STATS_EN
    , .stat_rd(a_st_rd), .stat_wr(a_st_wr), .stat_stall(a_st_stall)
`endif
  );

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(2), .RESP_DEPTH(4)) u_lat2 (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(b_addr_ok), .rdata(b_rdata), .data_ok(b_data_ok), .data_ready(data_ready),
    .sram_en(b_en), .sram_wen(b_wen), .sram_addr(b_saddr), .sram_wdata(b_swdata),
    .sram_rdata(b_srdata)
`ifdef SRAM_LIKE_BRIDGE_STATS_EN
    , .stat_rd(b_st_rd), .stat_wr(b_st_wr), .stat_stall(b_st_stall)
`endif
  );

  // SRAM content is a fixed function of the word address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a == 32'h1000) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  logic [31:0] b_stage;
  always @(posedge clk) begin
    a_srdata <= a_en ? data_of(a_saddr) : 32'h0;
    b_stage  <= b_en ? data_of(b_saddr) : 32'h0;
    b_srdata <= b_stage;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    req    = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_wen;
    logic [31:0] exp_saddr;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{1'b0, 2'd2, 32'h1000, 32'h0000_0000, 4'b0000, 32'h1000};
    vecs[1] = '{1'b1, 2'd0, 32'h1003, 32'h1122_3344, 4'b1000, 32'h1000};
    vecs[2] = '{1'b1, 2'd1, 32'h1002, 32'h5566_7788, 4'b1100, 32'h1000};
    vecs[3] = '{1'b1, 2'd2, 32'h1001, 32'h99AA_BBCC, 4'b1111, 32'h1000};
    vecs[4] = '{1'b1, 2'd0, 32'h2001, 32'h0000_AB00, 4'b0010, 32'h2000};
    vecs[5] = '{1'b1, 2'd1, 32'h2000, 32'h0000_1234, 4'b0011, 32'h2000};
    vecs[6] = '{1'b1, 2'd1, 32'h2003, 32'hCD00_0000, 4'b1000, 32'h2000};
    vecs[7] = '{1'b1, 2'd3, 32'h2002, 32'hFEED_F00D, 4'b1111, 32'h2000};
    vecs[8] = '{1'b0, 2'd0, 32'h2005, 32'h0000_0000, 4'b0000, 32'h2004};
    vecs[9] = '{1'b0, 2'd1, 32'h3FFE, 32'h0000_0000, 4'b0000, 32'h3FFC};

    resetn = 1'b0; req = 1'b1; wr = 1'b1; size = 2'd2;
    addr = 32'h1003; wdata = 32'h0; data_ready = 1'b1;
    step();
    step();
    check("rst a_addr_ok", 32'(a_addr_ok), 0);
    check("rst b_addr_ok", 32'(b_addr_ok), 0);
    check("rst a_data_ok", 32'(a_data_ok), 0);
    check("rst b_data_ok", 32'(b_data_ok), 0);
    check("rst a_sram_en", 32'(a_en), 0);
    check("rst b_sram_wen", 32'(b_wen), 0);
`ifdef SRAM_LIKE_BRIDGE_STATS_EN
    check("rst b_stat_rd", b_st_rd, 0);
    check("rst b_stat_stall", b_st_stall, 0);
`endif
    req    = 1'b0;
    resetn = 1'b1;

    // Streaming table: one request per cycle, both latencies answered at full rate.
    for (int i = 0; i < NV + 2; i++) begin
      step();
      if (i < NV) begin
        req = 1'b1; wr = vecs[i].wr; size = vecs[i].size;
        addr = vecs[i].addr; wdata = vecs[i].wdata;
      end else begin
        req = 1'b0;
      end
      #1;
      if (i < NV) begin
        check($sformatf("vec%0d a_addr_ok", i), 32'(a_addr_ok), 1);
        check($sformatf("vec%0d a_sram_en", i), 32'(a_en), 1);
        check($sformatf("vec%0d a_sram_wen", i), 32'(a_wen), 32'(vecs[i].exp_wen));
        check($sformatf("vec%0d b_sram_wen", i), 32'(b_wen), 32'(vecs[i].exp_wen));
        check($sformatf("vec%0d a_sram_addr", i), a_saddr, vecs[i].exp_saddr);
        if (vecs[i].wr) check($sformatf("vec%0d a_sram_wdata", i), a_swdata, vecs[i].wdata);
      end
      if (i >= 1 && i <= NV) begin
        check($sformatf("vec%0d a_data_ok", i - 1), 32'(a_data_ok), 1);
        if (!vecs[i-1].wr)
          check($sformatf("vec%0d a_rdata", i - 1), a_rdata, data_of(vecs[i-1].exp_saddr));
      end else begin
        check($sformatf("cyc%0d a_data_ok idle", i), 32'(a_data_ok), 0);
      end
      if (i >= 2) begin
        check($sformatf("vec%0d b_data_ok", i - 2), 32'(b_data_ok), 1);
        if (!vecs[i-2].wr)
          check($sformatf("vec%0d b_rdata", i - 2), b_rdata, data_of(vecs[i-2].exp_saddr));
      end else begin
        check($sformatf("cyc%0d b_data_ok idle", i), 32'(b_data_ok), 0);
      end
    end
    step();
    check("stream end b_data_ok", 32'(b_data_ok), 0);

    // Back-pressure on the SRAM_LAT=2 instance: four credits, fifth request waits.
    pulse_reset();
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'(i * 4);
      #1;
      check($sformatf("bp req%0d b_addr_ok", i), 32'(b_addr_ok), 32'(i < 4));
      check($sformatf("bp req%0d b_sram_en", i), 32'(b_en), 32'(i < 4));
    end
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("bp hold%0d b_addr_ok", i), 32'(b_addr_ok), 0);
      check($sformatf("bp hold%0d b_data_ok", i), 32'(b_data_ok), 1);
      check($sformatf("bp hold%0d b_rdata", i), b_rdata, data_of(32'h0));
    end
    step();
    data_ready = 1'b1;
    #1;
    check("bp pop@full b_addr_ok", 32'(b_addr_ok), 0);
    check("bp pop@full b_rdata", b_rdata, data_of(32'h0));
    step();
    check("bp retry b_addr_ok", 32'(b_addr_ok), 1);
    check("bp retry b_sram_addr", b_saddr, 32'h10);
    check("bp resp1 b_rdata", b_rdata, data_of(32'h4));
    for (int k = 0; k < 3; k++) begin
      step();
      req = 1'b0;
      #1;
      check($sformatf("bp resp%0d b_data_ok", k + 2), 32'(b_data_ok), 1);
      check($sformatf("bp resp%0d b_rdata", k + 2), b_rdata, data_of(32'(8 + 4 * k)));
    end
    step();
    check("bp drained b_data_ok", 32'(b_data_ok), 0);

    // Reset with two reads in flight; afterwards all four credits must be free again.
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      step();
      req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'(32'h40 + 4 * k);
      #1;
      check($sformatf("inflight%0d b_addr_ok", k), 32'(b_addr_ok), 1);
    end
    step();
    resetn = 1'b0; req = 1'b1; wr = 1'b1; addr = 32'h48;
    #1;
    check("midrst a_addr_ok", 32'(a_addr_ok), 0);
    check("midrst b_addr_ok", 32'(b_addr_ok), 0);
    check("midrst a_data_ok", 32'(a_data_ok), 0);
    check("midrst b_data_ok", 32'(b_data_ok), 0);
    check("midrst b_sram_en", 32'(b_en), 0);
    check("midrst a_sram_wen", 32'(a_wen), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      resetn = 1'b1; data_ready = 1'b0;
      req = 1'b1; wr = 1'b0; addr = 32'(32'h50 + 4 * k);
      #1;
      check($sformatf("postrst req%0d b_addr_ok", k), 32'(b_addr_ok), 32'(k < 4));
      if (k < 2) check($sformatf("postrst cyc%0d b_data_ok", k), 32'(b_data_ok), 0);
      if (k == 0) check("postrst a_data_ok", 32'(a_data_ok), 0);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      req = 1'b0; data_ready = 1'b1;
      #1;
      check($sformatf("postrst resp%0d b_data_ok", k), 32'(b_data_ok), 1);
      check($sformatf("postrst resp%0d b_rdata", k), b_rdata, data_of(32'(32'h50 + 4 * k)));
    end
    step();
    check("postrst drained b_data_ok", 32'(b_data_ok), 0);

`ifdef SRAM_LIKE_BRIDGE_STATS_EN
    // 3 reads + 1 write fill the credits, the second write stalls 4 cycles.
    pulse_reset();
    data_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      data_ready = (k >= 7);
      req = 1'b1; wr = (k >= 3); size = 2'd2;
      addr = 32'(32'h100 + 4 * ((k < 4) ? k : 4));
      #1;
      check($sformatf("stats cyc%0d b_addr_ok", k), 32'(b_addr_ok), 32'(k < 4 || k == 8));
    end
    step();
    req = 1'b0;
    #1;
    check("b_stat_rd", b_st_rd, 3);
    check("b_stat_wr", b_st_wr, 2);
    check("b_stat_stall", b_st_stall, 4);
    check("a_stat_stall", a_st_stall, 4);
    for (int k = 0; k < 6; k++) step();
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
